// File: rtl/seq_div_8by4.sv
// Sequential 8-by-4 unsigned restoring divider.
// One quotient bit per cycle, MSB first, with divide-by-zero shortcut.
module seq_div_8by4 (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] dividend,
  input  logic [3:0] divisor,
  output logic       busy,
  output logic       done,
  output logic [7:0] quotient,
  output logic [3:0] remainder,
  output logic       div_zero
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  dvd_q, dvd_d;
  logic [3:0]  dvs_q, dvs_d;
  logic [7:0]  quo_q, quo_d;
  logic [4:0]  rem_q, rem_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [7:0]  q_out_q, q_out_d;
  logic [3:0]  r_out_q, r_out_d;
  logic        dz_q, dz_d;

  logic [4:0]  shifted;
  logic [5:0]  diff;
  logic        fits;
  logic [4:0]  rem_nxt;
  logic [7:0]  quo_nxt;
  logic        dvs_zero;

  // Remainder stays below the divisor, so bit 4 is only ever set post-shift.
  always_comb begin
    shifted  = {rem_q[3:0], dvd_q[7]};
    diff     = {1'b0, shifted} - {2'b00, dvs_q};
    fits     = ~diff[5];
    rem_nxt  = fits ? diff[4:0] : shifted;
    quo_nxt  = {quo_q[6:0], fits};
    dvs_zero = (dvs_q == 4'd0);
  end

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    q_out_d = q_out_q;
    r_out_d = r_out_q;
    dz_d    = dz_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          dvd_d = dividend;
          dvs_d = divisor;
          quo_d = 8'd0;
          rem_d = 5'd0;
          cnt_d = 3'd0;
          if (divisor == 4'd0) begin
            state_d = DONE;
            done_d  = 1'b1;
            q_out_d = 8'hFF;
            r_out_d = 4'h0;
            dz_d    = 1'b1;
          end else begin
            state_d = CALC;
            busy_d  = 1'b1;
          end
        end
      end
      CALC: begin
        dvd_d = {dvd_q[6:0], 1'b0};
        rem_d = rem_nxt;
        quo_d = quo_nxt;
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          q_out_d = dvs_zero ? 8'hFF : quo_nxt;
          r_out_d = dvs_zero ? 4'h0 : rem_nxt[3:0];
          dz_d    = dvs_zero;
        end
      end
      DONE: begin
        if (start) begin
          dvd_d   = dividend;
          dvs_d   = divisor;
          quo_d   = 8'd0;
          rem_d   = 5'd0;
          cnt_d   = 3'd0;
          state_d = CALC;
          busy_d  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      dvd_q   <= 8'd0;
      dvs_q   <= 4'd0;
      quo_q   <= 8'd0;
      rem_q   <= 5'd0;
      cnt_q   <= 3'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      q_out_q <= 8'd0;
      r_out_q <= 4'd0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      q_out_q <= q_out_d;
      r_out_q <= r_out_d;
      dz_q    <= dz_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = q_out_q;
  assign remainder = r_out_q;
  assign div_zero  = dz_q;

endmodule
